// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector with
// overlapping/non-overlapping modes and a saturating match counter.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    input  logic               clr_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill
);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] window, window_next, mask;
    logic [LEN_W-1:0]   fill_inc, fill_next;
    logic               len_ok, hit;

    always_comb begin
        len_ok      = (len != '0) && (len <= MAX_L);
        mask        = ~({MAX_LEN{1'b1}} << len);
        window_next = en ? {window[MAX_LEN-2:0], din} : window;
        fill_inc    = (fill >= len) ? len : fill + LEN_W'(1);
        hit         = en && len_ok && (fill_inc == len) && (((window_next ^ pattern) & mask) == '0);
        // Non-overlapping mode discards history on a hit so the next match needs len fresh samples
        fill_next   = !len_ok         ? '0 :
                      hit && !overlap ? '0 :
                      en              ? fill_inc :
                      (fill > len)    ? len : fill;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window      <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            window      <= window_next;
            fill        <= fill_next;
            match       <= hit;
            match_count <= clr_cnt ? '0 :
                           (hit && match_count != '1) ? match_count + CNT_W'(1) : match_count;
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed plus random stimulus checked against a
// queue-based history model of the detector.
module tb_seq_detector_param;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n, en, din, overlap, clr_cnt;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic [LEN_W-1:0]   fill;

    int checks = 0;
    int errors = 0;

    bit hist[$];
    int m_fill = 0;
    int m_cnt  = 0;
    bit m_match = 0;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .pattern(pattern),
        .len(len), .overlap(overlap), .clr_cnt(clr_cnt),
        .match(match), .match_count(match_count), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the last len received bits must equal pattern, with at least len
    // valid samples counted since reset or the previous non-overlapping match.
    task automatic model_edge();
        int  l;
        int  f;
        bit  ok;
        l = int'(len);
        if (!rst_n) begin
            hist.delete();
            m_fill = 0; m_cnt = 0; m_match = 0;
            return;
        end
        if (en) begin
            hist.push_back(din);
            if (hist.size() > 32) void'(hist.pop_front());
        end
        m_match = 0;
        if (l < 1 || l > MAX_LEN) m_fill = 0;
        else if (en) begin
            f  = (m_fill + 1 < l) ? m_fill + 1 : l;
            ok = (f == l);
            for (int i = 0; i < l; i++)
                if (i >= hist.size() || hist[hist.size()-1-i] != pattern[i]) ok = 0;
            m_match = ok;
            m_fill  = (ok && !overlap) ? 0 : f;
        end else if (m_fill > l) m_fill = l;
        m_cnt = clr_cnt ? 0 : (m_match && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    endtask

    task automatic step(input bit e, input bit d);
        en = e; din = d;
        model_edge();
        @(posedge clk); #1;
        chk("match", match, m_match);
        chk("match_count", match_count, m_cnt);
        chk("fill", fill, m_fill);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1, 1);
        rst_n = 1'b1;
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1, bits[i]);
    endtask

    initial begin
        rst_n = 0; en = 1; din = 1; clr_cnt = 0; overlap = 1;
        pattern = 8'b0000_1011; len = 4;
        @(negedge clk);
        step(1, 1); step(1, 1);
        chk("reset_match", match, 0);
        chk("reset_count", match_count, 0);
        chk("reset_fill", fill, 0);
        rst_n = 1;
        step(1, 1);
        chk("fill_after_release", fill, 1);

        do_reset();
        feed(32'b1011011, 7);
        chk("overlap_count", match_count, 2);

        overlap = 0;
        do_reset();
        feed(32'b1011011, 7);
        chk("nonoverlap_count", match_count, 1);
        chk("nonoverlap_fill", fill, 3);

        overlap = 1;
        do_reset();
        step(1, 1); step(1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1);
            chk("no_match_en_low", match, 0);
        end
        step(1, 1); step(1, 1);
        chk("en_gap_match", match, 1);
        chk("en_gap_count", match_count, 1);

        len = 0;
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 1'($urandom));
        chk("len0_count", match_count, 0);
        chk("len0_fill", fill, 0);

        len = 8; pattern = 8'hA5;
        do_reset();
        feed(32'b10100101, 8);
        chk("len8_match", match, 1);
        chk("len8_count", match_count, 1);

        len = 1; pattern = 8'h01;
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1);
        chk("sat_count", match_count, CNT_MAX);
        clr_cnt = 1;
        step(1, 1);
        chk("clr_priority", match_count, 0);
        clr_cnt = 0;
        step(1, 1);
        chk("count_after_clr", match_count, 1);

        len = 4; pattern = 8'b0000_1011;
        do_reset();
        feed(32'b101, 3);
        do_reset();
        step(1, 1);
        chk("midreset_match", match, 0);
        chk("midreset_fill", fill, 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) len = LEN_W'($urandom_range(0, 10));
            if ($urandom_range(0, 15) == 0) overlap = 1'($urandom);
            if ($urandom_range(0, 31) == 0) pattern = MAX_LEN'($urandom);
            if ($urandom_range(0, 7) == 0) pattern[1:0] = 2'($urandom);
            clr_cnt = ($urandom_range(0, 19) == 0);
            rst_n   = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 2) != 0));
        end
        rst_n = 1; clr_cnt = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
